// File: rtl/program_loader_pkg.sv
// Shared definitions for the program RAM loader: sync byte, FSM states and
// the mod-2^DATA_WIDTH checksum helper.
package program_loader_pkg;

    localparam int DATA_WIDTH = 8;
    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        GET_ADDR  = 3'd1,
        GET_LEN   = 3'd2,
        GET_DATA  = 3'd3,
        GET_CSUM  = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } loader_state_t;

    function automatic logic [DATA_WIDTH-1:0] csum_add(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] data
    );
        return acc + data;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
// master = byte source / RAM side, slave = loader.
interface program_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_data_o;

    modport master (
        output in_data_i, in_valid_i,
        input  in_ready_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport slave (
        input  in_data_i, in_valid_i,
        output in_ready_o, ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/program_loader_timeout.sv
// Idle counter for the loader: counts cycles while run is high, clears on
// clear, and flags expiry after TIMEOUT_CYCLES idle cycles.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_r;

    // expired is seen one cycle early so the FSM leaves on the TIMEOUT_CYCLES-th idle edge
    assign expired = run && (cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Idle cycle counter, saturating at the expiry value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!run || clear) begin
            cnt_r <= '0;
        end else if (!expired) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream into program RAM and holds the CPU in reset
// until a frame with a good checksum has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = program_loader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_hold_o,
    output logic             done_o,
    output logic             error_o
);
    loader_state_t         state_r, next_state_s;
    logic                  ready_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [8:0]            len_cnt_r;
    logic [DATA_WIDTH-1:0] csum_r;

    logic                  ram_we_r, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_r, ram_data_d;
    logic                  hold_r, hold_d;
    logic                  done_r, done_d;
    logic                  error_r, error_d;

    logic accept_s, is_sync_s, csum_ok_s, run_s, expired_s;

    assign accept_s  = bus.in_valid_i && ready_r;
    assign is_sync_s = (bus.in_data_i == DATA_WIDTH'(LOADER_SYNC_BYTE));
    assign csum_ok_s = (csum_add(csum_r, bus.in_data_i) == '0);
    assign run_s     = (state_r == GET_ADDR) || (state_r == GET_LEN) ||
                       (state_r == GET_DATA) || (state_r == GET_CSUM);

    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (reset),
        .run     (run_s),
        .clear   (accept_s),
        .expired (expired_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= WAIT_SYNC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; an accepted byte always beats a timeout on the same edge
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            WAIT_SYNC, DONE, ERROR: begin
                if (accept_s && is_sync_s) next_state_s = GET_ADDR;
                else                       next_state_s = state_r;
            end
            GET_ADDR: begin
                if (accept_s)       next_state_s = GET_LEN;
                else if (expired_s) next_state_s = ERROR;
                else                next_state_s = state_r;
            end
            GET_LEN: begin
                if (accept_s)       next_state_s = GET_DATA;
                else if (expired_s) next_state_s = ERROR;
                else                next_state_s = state_r;
            end
            GET_DATA: begin
                if (accept_s && (len_cnt_r == 9'd1)) next_state_s = GET_CSUM;
                else if (accept_s)                   next_state_s = GET_DATA;
                else if (expired_s)                  next_state_s = ERROR;
                else                                 next_state_s = state_r;
            end
            GET_CSUM: begin
                if (accept_s && csum_ok_s) next_state_s = DONE;
                else if (accept_s)         next_state_s = ERROR;
                else if (expired_s)        next_state_s = ERROR;
                else                       next_state_s = state_r;
            end
            default: next_state_s = WAIT_SYNC;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_r;
        ram_data_d = ram_data_r;
        if (accept_s && (state_r == GET_DATA)) begin
            ram_we_d   = 1'b1;
            ram_addr_d = wr_addr_r;
            ram_data_d = bus.in_data_i;
        end else begin
            ram_we_d   = 1'b0;
        end
        hold_d  = (next_state_s != DONE);
        done_d  = (next_state_s == DONE);
        error_d = (next_state_s == ERROR);
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r    <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= '0;
            ram_data_r <= '0;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            ready_r    <= 1'b1;
            ram_we_r   <= ram_we_d;
            ram_addr_r <= ram_addr_d;
            ram_data_r <= ram_data_d;
            hold_r     <= hold_d;
            done_r     <= done_d;
            error_r    <= error_d;
        end
    end

    // Frame datapath: write address, remaining byte count, running checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr_r <= '0;
            len_cnt_r <= 9'd0;
            csum_r    <= '0;
        end else if (accept_s) begin
            case (state_r)
                GET_ADDR: begin
                    wr_addr_r <= ADDR_WIDTH'(bus.in_data_i);
                    csum_r    <= bus.in_data_i;
                end
                GET_LEN: begin
                    // LEN of zero encodes a full 256-byte frame
                    len_cnt_r <= (bus.in_data_i == '0) ? 9'd256 : 9'(bus.in_data_i);
                    csum_r    <= csum_add(csum_r, bus.in_data_i);
                end
                GET_DATA: begin
                    wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
                    len_cnt_r <= len_cnt_r - 9'd1;
                    csum_r    <= csum_add(csum_r, bus.in_data_i);
                end
                default: begin
                    wr_addr_r <= wr_addr_r;
                    len_cnt_r <= len_cnt_r;
                    csum_r    <= csum_r;
                end
            endcase
        end else begin
            wr_addr_r <= wr_addr_r;
            len_cnt_r <= len_cnt_r;
            csum_r    <= csum_r;
        end
    end

    assign bus.in_ready_o = ready_r;
    assign bus.ram_we_o   = ram_we_r;
    assign bus.ram_addr_o = ram_addr_r;
    assign bus.ram_data_o = ram_data_r;
    assign cpu_hold_o     = hold_r;
    assign done_o         = done_r;
    assign error_o        = error_r;
endmodule
